riscv_dmem_lsu: RTL

RISCV_DMEM_LSU -- requirements
Module: riscv_dmem_lsu

---
 rtl/riscv_dmem_lsu.sv | 118 +++++++++++
 1 files changed

// File: rtl/riscv_dmem_lsu.sv
// riscv_dmem_lsu: single-port data memory with byte/half/word load-store unit.
// Define RISCV_DMEM_MISALIGN_SPLIT_EN to split misaligned accesses over two cycles instead of faulting.
module riscv_dmem_lsu #(
    parameter int P_ADDR_BIT = 12,
    parameter int P_XLEN     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_req,
    output logic                  o_ready,
    input  logic                  i_wr,
    input  logic [P_ADDR_BIT-1:0] i_addr,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [P_XLEN-1:0]     i_wdata,
    output logic                  o_rvalid,
    output logic [P_XLEN-1:0]     o_rdata,
    output logic                  o_err
);
`ifdef RISCV_DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif
    localparam int IW    = P_ADDR_BIT - 2;
    localparam int DEPTH = 2 ** IW;

    typedef enum logic {IDLE, SPLIT} state_t;
    state_t state;

    logic [31:0]   mem [DEPTH];
    logic [IW-1:0] idx, sp_idx, w_idx;
    logic [1:0]    off, sp_off, sp_size, lsz;
    logic          sp_wr, sp_unsigned, lun, acc, aligned, split, w_en;
    logic [3:0]    be_base, sp_be, w_be;
    logic [7:0]    be_sh;
    logic [63:0]   wd_sh, rd_cat;
    logic [31:0]   sp_data, sp_lo, w_data, rw, ld;

    // Both halves of any access are viewed as an 8-lane window over words N and N+1.
    always_comb begin
        idx     = i_addr[P_ADDR_BIT-1:2];
        off     = i_addr[1:0];
        split   = state == SPLIT;
        acc     = i_req & o_ready;
        aligned = (i_size == 2'b00) | (i_size == 2'b01 & ~off[0]) | (i_size[1] & off == 2'b00);
        be_base = i_size == 2'b00 ? 4'b0001 : i_size == 2'b01 ? 4'b0011 : 4'b1111;
        be_sh   = {4'b0000, be_base} << off;
        wd_sh   = {32'b0, i_wdata} << {off, 3'b000};
        w_en    = i_rstn & (split ? sp_wr : acc & i_wr & (aligned | SPLIT_EN));
        w_idx   = split ? sp_idx : idx;
        w_be    = split ? sp_be : be_sh[3:0];
        w_data  = split ? sp_data : wd_sh[31:0];
        rd_cat  = split ? {mem[sp_idx], sp_lo} : {32'b0, mem[idx]};
        rw      = 32'(rd_cat >> {split ? sp_off : off, 3'b000});
        lsz     = split ? sp_size : i_size;
        lun     = split ? sp_unsigned : i_unsigned;
        ld      = lsz == 2'b00 ? {{24{~lun & rw[7]}}, rw[7:0]}
                : lsz == 2'b01 ? {{16{~lun & rw[15]}}, rw[15:0]} : rw;
    end

    always_ff @(posedge i_clk) begin
        if (w_en)
            for (int b = 0; b < 4; b++)
                if (w_be[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            o_ready     <= 1'b1;
            o_rvalid    <= 1'b0;
            o_err       <= 1'b0;
            o_rdata     <= '0;
            sp_wr       <= 1'b0;
            sp_idx      <= '0;
            sp_be       <= '0;
            sp_data     <= '0;
            sp_lo       <= '0;
            sp_off      <= '0;
            sp_size     <= '0;
            sp_unsigned <= 1'b0;
        end else begin
            o_rvalid <= 1'b0;
            o_err    <= 1'b0;
            if (state == IDLE) begin
                if (acc) begin
                    if (aligned) begin
                        if (!i_wr) begin
                            o_rvalid <= 1'b1;
                            o_rdata  <= ld;
                        end
                    end else if (SPLIT_EN) begin
                        state       <= SPLIT;
                        o_ready     <= 1'b0;
                        sp_wr       <= i_wr;
                        sp_idx      <= idx + IW'(1);
                        sp_be       <= be_sh[7:4];
                        sp_data     <= wd_sh[63:32];
                        sp_lo       <= mem[idx];
                        sp_off      <= off;
                        sp_size     <= i_size;
                        sp_unsigned <= i_unsigned;
                    end else begin
                        o_err <= 1'b1;
                    end
                end
            end else begin
                state   <= IDLE;
                o_ready <= 1'b1;
                if (!sp_wr) begin
                    o_rvalid <= 1'b1;
                    o_rdata  <= ld;
                end
            end
        end
    end
endmodule
